i2s_audio_tx: RTL and testbench

Parametrised I2S master transmitter for the audio codec path. It generates the codec master clock from the system clock with a configurable ratio. A sample FIFO accepts stereo words from the SoC side through a valid/ready handshake. The block produces BCLK, LRCLK and serial data in standard I2S framing and reports FIFO level and underruns. It sits beside the SoC in the top level and drives the codec pins on the Arduino header.

---
 rtl/i2s_audio_tx_if.sv | 10 +
 rtl/i2s_audio_tx.sv | 128 ++++++++++++
 tb/tb_i2s_audio_tx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2s_audio_tx_if.sv
// i2s_audio_tx_if: stereo sample push channel into the I2S transmitter FIFO.
interface i2s_audio_tx_if #(
    parameter int SAMPLE_W = 16
);
    logic [2*SAMPLE_W-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    modport master (output s_data, s_valid, input s_ready);
    modport slave (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: I2S master transmitter with sample FIFO, MCLK/BCLK generation and underrun counting.
// Define I2S_TX_HOLD_LAST_EN to repeat the last frame on underrun instead of sending silence.
module i2s_audio_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 32,
    parameter int MCLK_DIV   = 4,
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    i2s_audio_tx_if.slave               s,
    input  logic                        underrun_clr,
    output logic                        mclk,
    output logic                        bclk,
    output logic                        lrclk,
    output logic                        sdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 underrun_cnt
);
    localparam int FW = 2*SAMPLE_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int MW = $clog2(MCLK_DIV);
    localparam int BW = $clog2(BCLK_DIV);
    localparam int PW = $clog2(2*SLOT_W);
    localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV/2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] B_HALF = BW'(BCLK_DIV/2);
    localparam logic [PW-1:0] P_LAST = PW'(2*SLOT_W - 1);
    localparam logic [PW-1:0] P_SLOT = PW'(SLOT_W);
    localparam logic [PW-1:0] P_SAMP = PW'(SAMPLE_W);
    localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

    logic [MW-1:0]       mc_q, mc_d;
    logic                mclk_q, mclk_d;
    logic [BW-1:0]       bc_q, bc_d;
    logic [PW-1:0]       bitpos_q, bitpos_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                ready_q, ready_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [15:0]         ucnt_q, ucnt_d;
    logic [FW-1:0]       mem_q [FIFO_DEPTH];
    logic                ev, wrap, push, pop, under, lr_n, bit_n;
    logic [PW-1:0]       q;
    logic [SAMPLE_W-1:0] word, sh;

    always_comb begin
        mc_d     = (mc_q == M_LAST) ? '0 : mc_q + 1'b1;
        mclk_d   = (mc_q == M_LAST) ? ~mclk_q : mclk_q;
        ev       = enable && bc_q == B_LAST;
        wrap     = ev && bitpos_q == P_LAST;
        bc_d     = (!enable || ev) ? '0 : bc_q + 1'b1;
        bitpos_d = !enable ? P_LAST : !ev ? bitpos_q : (bitpos_q == P_LAST) ? '0 : bitpos_q + 1'b1;
        // Data is looked up for the position being entered, so the registered bit lines up with it.
        lr_n     = bitpos_d >= P_SLOT;
        q        = lr_n ? bitpos_d - P_SLOT : bitpos_d;
        word     = lr_n ? frame_q[SAMPLE_W-1:0] : frame_q[FW-1:SAMPLE_W];
        sh       = word << (q - 1'b1);
        bit_n    = (q != '0 && q <= P_SAMP) ? sh[SAMPLE_W-1] :
                   (q == '0 && SAMPLE_W == SLOT_W) ? (lr_n ? frame_q[SAMPLE_W] : frame_q[0]) : 1'b0;
        bclk_d   = enable && (bc_d == B_HALF || (!ev && bclk_q));
        lrclk_d  = enable && (ev ? lr_n : lrclk_q);
        sdata_d  = enable && (ev ? bit_n : sdata_q);
        push     = s.s_valid && ready_q;
        under    = wrap && level_q == '0;
        pop      = wrap && !under;
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop ? rd_q + 1'b1 : rd_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        ready_d  = level_d < L_FULL;
`ifdef I2S_TX_HOLD_LAST_EN
        frame_d  = pop ? mem_q[rd_q] : frame_q;
`else
        frame_d  = pop ? mem_q[rd_q] : under ? '0 : frame_q;
`endif
        ucnt_d   = underrun_clr ? '0 : (under && ucnt_q != 16'hFFFF) ? ucnt_q + 1'b1 : ucnt_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= s.s_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_q     <= '0;
            mclk_q   <= 1'b0;
            bc_q     <= '0;
            bitpos_q <= P_LAST;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdata_q  <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            frame_q  <= '0;
            ucnt_q   <= '0;
        end else begin
            mc_q     <= mc_d;
            mclk_q   <= mclk_d;
            bc_q     <= bc_d;
            bitpos_q <= bitpos_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            frame_q  <= frame_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign s.s_ready    = ready_q;
    assign mclk         = mclk_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign fifo_level   = level_q;
    assign underrun_cnt = ucnt_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: directed stimulus for i2s_audio_tx against a queue-based frame model.
module tb_i2s_audio_tx;
    localparam int SW = 16, SL = 32, MD = 4, BD = 4, DEPTH = 16;

    logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, underrun_clr = 1'b0;
    logic        mclk, bclk, lrclk, sdata;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_cnt;

    i2s_audio_tx_if #(.SAMPLE_W(SW)) bus ();

    i2s_audio_tx #(.SAMPLE_W(SW), .SLOT_W(SL), .MCLK_DIV(MD), .BCLK_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .s(bus.slave), .underrun_clr(underrun_clr),
        .mclk(mclk), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .fifo_level(fifo_level), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Model: k counts enabled edges since enable rose; frame position follows from k alone.
    logic [31:0] mq[$];
    logic [31:0] cur;
    int          m, k, ucnt, sz, p, qq;
    logic [15:0] w;
    logic        e_mclk, e_bclk, e_lr, e_sd;

    task automatic model_step();
        if (reset) begin
            mq.delete();
            cur = 0; m = 0; k = 0; ucnt = 0;
            e_mclk = 0; e_bclk = 0; e_lr = 0; e_sd = 0;
        end else begin
            sz = mq.size();
            m++;
            e_mclk = ((m / (MD/2)) % 2) == 1;
            if (enable) begin
                k++;
                if (k % BD == 0 && ((k/BD - 1) % (2*SL)) == 0) begin
                    if (sz > 0) cur = mq.pop_front();
                    else begin
                        if (ucnt < 65535) ucnt++;
`ifndef I2S_TX_HOLD_LAST_EN
                        cur = 0;
`endif
                    end
                end
            end else k = 0;
            if (bus.s_valid && sz < DEPTH) mq.push_back(bus.s_data);
            if (underrun_clr) ucnt = 0;
            e_bclk = enable && (k % BD) >= BD/2;
            e_lr = 0;
            e_sd = 0;
            if (enable && k >= BD) begin
                p = (k/BD - 1) % (2*SL);
                e_lr = p >= SL;
                qq = p % SL;
                w = e_lr ? cur[15:0] : cur[31:16];
                if (qq >= 1 && qq <= SW) e_sd = w[4'(SW-qq)];
            end
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    always @(negedge clk)
        check("cycle", 32'({mclk, bclk, lrclk, sdata, bus.s_ready, fifo_level, underrun_cnt}),
              32'({e_mclk, e_bclk, e_lr, e_sd, mq.size() < DEPTH, 5'(mq.size()), 16'(ucnt)}));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_k(input int n);
        int g = 0;
        while (k < n) begin
            tick();
            g++;
            if (g > 5000) begin
                failures++;
                $display("FAIL go_k timeout k=%0d want=%0d", k, n);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1);
            end
        end
    endtask

    task automatic grab(input int k0, output logic [15:0] v);
        for (int j = 0; j < 16; j++) begin
            go_k(k0 + BD*j);
            v[15-j] = sdata;
        end
    endtask

    logic [15:0] v;
    int          acc;

    initial begin
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hDEADBEEF;
        repeat (3) tick();
        check("rst_pins", 32'({mclk, bclk, lrclk, sdata}), 0);
        check("rst_ready", 32'(bus.s_ready), 1);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ucnt", 32'(underrun_cnt), 0);
        bus.s_valid = 1'b0;
        reset = 1'b0;
        tick(); check("mclk_e1", 32'(mclk), 0);
        tick(); check("mclk_e2", 32'(mclk), 1);
        tick(); check("mclk_e3", 32'(mclk), 1);
        tick(); check("mclk_e4", 32'(mclk), 0);

        bus.s_data = {16'hA5F0, 16'h0F5A};
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        check("sf_level", 32'(fifo_level), 1);
        enable = 1'b1;
        grab(8, v);
        check("sf_left", 32'(v), 32'hA5F0);
        go_k(131); check("sf_lr131", 32'(lrclk), 0);
        go_k(132); check("sf_lr132", 32'(lrclk), 1);
        grab(136, v);
        check("sf_right", 32'(v), 32'h0F5A);
        go_k(259); check("sf_ucnt0", 32'(underrun_cnt), 0);
        go_k(260); check("sf_ucnt1", 32'(underrun_cnt), 1);
        enable = 1'b0;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("sf_clr", 32'(underrun_cnt), 0);

        acc = 0;
        for (int i = 0; i < 20; i++) begin
            bus.s_data = {16'(16'h1000 + i), 16'(16'h2000 + i)};
            bus.s_valid = 1'b1;
            if (bus.s_ready) acc++;
            tick();
        end
        bus.s_valid = 1'b0;
        check("full_level", 32'(fifo_level), 16);
        check("full_ready", 32'(bus.s_ready), 0);
        check("full_acc", 32'(acc), 16);

        enable = 1'b1;
        go_k(86);
        check("dis_bclk_hi", 32'(bclk), 1);
        enable = 1'b0;
        tick();
        check("dis_pins", 32'({bclk, lrclk, sdata}), 0);
        repeat (5) tick();
        check("dis_level", 32'(fifo_level), 15);
        enable = 1'b1;
        grab(8, v);
        check("reen_left", 32'(v), 32'h1001);
        grab(136, v);
        check("reen_right", 32'(v), 32'h2001);

        go_k(150);
        reset = 1'b1;
        #1;
        check("mid_rst_pins", 32'({mclk, bclk, lrclk, sdata}), 0);
        check("mid_rst_ready", 32'(bus.s_ready), 1);
        check("mid_rst_level", 32'(fifo_level), 0);
        enable = 1'b0;
        tick();
        reset = 1'b0;

        bus.s_data = {16'h3333, 16'h4444};
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        enable = 1'b1;
        go_k(3);
        bus.s_data = {16'h5555, 16'h6666};
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        check("pp1_level", 32'(fifo_level), 1);
        check("pp1_ucnt", 32'(underrun_cnt), 0);
        grab(8, v);
        check("pp1_left", 32'(v), 32'h3333);
        go_k(260); check("pp_drain", 32'(fifo_level), 0);
        go_k(515);
        bus.s_data = {16'h7777, 16'h8888};
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        check("pp0_ucnt", 32'(underrun_cnt), 1);
        check("pp0_level", 32'(fifo_level), 1);

        enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enable = 1'b1;
        go_k(515); check("ur_ucnt2", 32'(underrun_cnt), 2);
        go_k(516); check("ur_ucnt3", 32'(underrun_cnt), 3);
        go_k(600);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("ur_clr", 32'(underrun_cnt), 0);
        enable = 1'b0;
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
